down_sampler_mc: RTL and testbench



---
 rtl/down_sampler_mc_pkg.sv | 34 +++
 rtl/down_sampler_mc_if.sv | 42 ++++
 rtl/down_sampler_mc_ds_chan_acc.sv | 50 +++++
 rtl/down_sampler_mc.sv | 100 ++++++++++
 tb/tb_down_sampler_mc.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/down_sampler_mc_pkg.sv
// Shared types and helpers for the multi-channel decimator: mode encoding,
// default geometry and the ratio-field width derivation.
package down_sampler_mc_pkg;

  typedef enum logic {
    MODE_PICK = 1'b0,
    MODE_AVG  = 1'b1
  } mode_e;

  localparam int unsigned DATA_WIDTH_DEF     = 32;
  localparam int unsigned NUM_CH_DEF         = 2;
  localparam int unsigned MAX_RATIO_LOG2_DEF = 4;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

  // Width of the requested-ratio field, able to hold 0..max_ratio_log2.
  function automatic int unsigned ratio_lw(input int unsigned max_ratio_log2);
    int unsigned w;
    w = clog2(max_ratio_log2 + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/down_sampler_mc_if.sv
// Sample-stream and configuration bundle between the sample source and the
// decimator; master drives the stream and cfg, slave is the decimator.
interface down_sampler_mc_if
  import down_sampler_mc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned NUM_CH         = NUM_CH_DEF,
  parameter int unsigned MAX_RATIO_LOG2 = MAX_RATIO_LOG2_DEF
) ();

  localparam int unsigned RLW = ratio_lw(MAX_RATIO_LOG2);
  localparam int unsigned BW  = NUM_CH * DATA_WIDTH;

  logic [RLW-1:0] cfg_ratio_log2;
  logic           cfg_mode;
  logic           sync_clr;
  logic [BW-1:0]  data_in;
  logic           data_in_vld;
  logic [BW-1:0]  data_out;
  logic           data_out_vld;

  modport master (
    output cfg_ratio_log2,
    output cfg_mode,
    output sync_clr,
    output data_in,
    output data_in_vld,
    input  data_out,
    input  data_out_vld
  );

  modport slave (
    input  cfg_ratio_log2,
    input  cfg_mode,
    input  sync_clr,
    input  data_in,
    input  data_in_vld,
    output data_out,
    output data_out_vld
  );

endinterface

// File: rtl/down_sampler_mc_ds_chan_acc.sv
// Per-channel datapath of the decimator: group accumulator and the registered
// output slice for one channel.
module down_sampler_mc_ds_chan_acc
  import down_sampler_mc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned MAX_RATIO_LOG2 = MAX_RATIO_LOG2_DEF,
  parameter int unsigned RLW            = ratio_lw(MAX_RATIO_LOG2_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic                  accept,
  input  logic                  first_smp,
  input  logic                  last_smp,
  input  mode_e                 mode,
  input  logic [RLW-1:0]        ratio_log2,
  output logic [DATA_WIDTH-1:0] data_out
);

  // Headroom of MAX_RATIO_LOG2 bits holds the sum of up to 2^MAX_RATIO_LOG2 samples.
  localparam int unsigned AW = DATA_WIDTH + MAX_RATIO_LOG2;

  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] sample_ext;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] avg;

  // The first sample of a group replaces the stale accumulator instead of adding to it.
  always_comb begin
    sample_ext = AW'($signed(sample));
    sum        = first_smp ? sample_ext : acc_q + sample_ext;
    avg        = sum >>> ratio_log2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      data_out <= '0;
    end else if (accept) begin
      acc_q <= sum;
      if (mode == MODE_PICK && first_smp) begin
        data_out <= sample;
      end else if (mode == MODE_AVG && last_smp) begin
        data_out <= DATA_WIDTH'(avg);
      end
    end
  end

endmodule

// File: rtl/down_sampler_mc.sv
// Multi-channel run-time configurable decimator: one output per 2^R accepted
// samples, either the first sample of the group (PICK) or its floor mean (AVG).
module down_sampler_mc
  import down_sampler_mc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned NUM_CH         = NUM_CH_DEF,
  parameter int unsigned MAX_RATIO_LOG2 = MAX_RATIO_LOG2_DEF
) (
  input logic               clk,
  input logic               rst,
  down_sampler_mc_if.slave  bus
);

  localparam int unsigned RLW = ratio_lw(MAX_RATIO_LOG2);
  localparam int unsigned PW  = (MAX_RATIO_LOG2 > 0) ? MAX_RATIO_LOG2 : 1;
  localparam int unsigned PW1 = PW + 1;
  localparam int unsigned BW  = NUM_CH * DATA_WIDTH;

  logic [PW-1:0]  phase_q;
  logic [PW-1:0]  phase_d;
  logic [PW-1:0]  last_phase;
  logic [RLW-1:0] shadow_r_q;
  logic [RLW-1:0] cfg_r_clamped;
  logic [RLW-1:0] eff_r;
  mode_e          shadow_mode_q;
  mode_e          cfg_mode_in;
  mode_e          eff_mode;
  logic           first_smp;
  logic           last_smp;
  logic           accept;
  logic           vld_q;
  logic           vld_d;
  logic [BW-1:0]  data_out_q;

  // Group sequencing: cfg is live at phase 0 and frozen in the shadow for the rest of the group.
  always_comb begin
    cfg_r_clamped = bus.cfg_ratio_log2;
    if (bus.cfg_ratio_log2 > RLW'(MAX_RATIO_LOG2)) begin
      cfg_r_clamped = RLW'(MAX_RATIO_LOG2);
    end
    cfg_mode_in = mode_e'(bus.cfg_mode);

    first_smp  = (phase_q == '0);
    eff_r      = first_smp ? cfg_r_clamped : shadow_r_q;
    eff_mode   = first_smp ? cfg_mode_in : shadow_mode_q;
    last_phase = PW'((PW1'(1) << eff_r) - PW1'(1));
    last_smp   = (phase_q == last_phase);

    // sync_clr wins over a coincident valid sample.
    accept = bus.data_in_vld && !bus.sync_clr;

    phase_d = phase_q;
    if (bus.sync_clr) begin
      phase_d = '0;
    end else if (accept) begin
      phase_d = last_smp ? '0 : phase_q + PW'(1);
    end

    vld_d = accept && ((eff_mode == MODE_PICK) ? first_smp : last_smp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q       <= '0;
      shadow_r_q    <= '0;
      shadow_mode_q <= MODE_PICK;
      vld_q         <= 1'b0;
    end else begin
      phase_q <= phase_d;
      vld_q   <= vld_d;
      if (accept && first_smp) begin
        shadow_r_q    <= cfg_r_clamped;
        shadow_mode_q <= cfg_mode_in;
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    down_sampler_mc_ds_chan_acc #(
      .DATA_WIDTH     (DATA_WIDTH),
      .MAX_RATIO_LOG2 (MAX_RATIO_LOG2),
      .RLW            (RLW)
    ) u_acc (
      .clk        (clk),
      .rst        (rst),
      .sample     (bus.data_in[k*DATA_WIDTH +: DATA_WIDTH]),
      .accept     (accept),
      .first_smp  (first_smp),
      .last_smp   (last_smp),
      .mode       (eff_mode),
      .ratio_log2 (eff_r),
      .data_out   (data_out_q[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign bus.data_out     = data_out_q;
  assign bus.data_out_vld = vld_q;

endmodule

// File: tb/tb_down_sampler_mc.sv
// Scoreboard bench for down_sampler_mc: a group-level reference model predicts
// each output and its cycle; a negedge monitor checks outputs and hold behaviour.
module tb_down_sampler_mc;
  import down_sampler_mc_pkg::*;

  localparam int unsigned DW  = 32;
  localparam int unsigned NCH = 2;
  localparam int unsigned MRL = 4;
  localparam int unsigned BW  = NCH * DW;

  typedef struct {
    logic [BW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  exp_t          exp_q[$];
  logic [BW-1:0] grp[$];
  int            g_r;
  bit            g_mode;
  bit            rst_at[int];
  logic [2:0]    cur_r = 3'd0;
  bit            cur_m = 1'b0;

  down_sampler_mc_if bus ();

  down_sampler_mc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack2(input int a, input int b);
    return {DW'(b), DW'(a)};
  endfunction

  // Floor of the arithmetic mean of one channel over the completed group.
  function automatic logic [DW-1:0] floor_mean(input int ch, input int n);
    longint s;
    longint q;
    logic [DW-1:0] v;
    s = 0;
    foreach (grp[i]) begin
      v = grp[i][ch*DW +: DW];
      s += longint'($signed(v));
    end
    q = s / n;
    if ((s % n) != 0 && s < 0) q = q - 1;
    return DW'(q);
  endfunction

  // Drive one cycle of stimulus and update the reference model for the coming edge.
  task automatic step(input bit vld, input logic [BW-1:0] d, input bit clr, input bit r);
    exp_t e;
    int   n;
    @(posedge clk);
    #1;
    rst                = r;
    bus.data_in_vld    = vld;
    bus.data_in        = d;
    bus.sync_clr       = clr;
    bus.cfg_ratio_log2 = cur_r;
    bus.cfg_mode       = cur_m;
    if (r) begin
      grp.delete();
      rst_at[cyc + 1] = 1'b1;
    end else if (clr) begin
      grp.delete();
    end else if (vld) begin
      if (grp.size() == 0) begin
        g_r    = (int'(cur_r) > int'(MRL)) ? int'(MRL) : int'(cur_r);
        g_mode = cur_m;
      end
      grp.push_back(d);
      n = 1 << g_r;
      if (g_mode == 1'b0 && grp.size() == 1) begin
        e.data = d;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
      end
      if (grp.size() == n) begin
        if (g_mode == 1'b1) begin
          for (int ch = 0; ch < int'(NCH); ch++) e.data[ch*DW +: DW] = floor_mean(ch, n);
          e.cyc = cyc + 1;
          exp_q.push_back(e);
        end
        grp.delete();
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Monitor: pulses must match the scoreboard in value and cycle; otherwise data_out holds.
  initial begin : monitor
    exp_t          e;
    logic [BW-1:0] exp_hold;
    exp_hold = '0;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        if (rst_at.exists(cyc)) exp_hold = '0;
        if (bus.data_out_vld) begin
          if (exp_q.size() == 0) begin
            check("vld_unexpected", BW'(bus.data_out_vld), '0);
          end else begin
            e = exp_q.pop_front();
            check("out_cycle", BW'(cyc), BW'(e.cyc));
            check("out_data", bus.data_out, e.data);
            exp_hold = e.data;
          end
        end else begin
          if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            check("vld_missing", BW'(bus.data_out_vld), BW'(1));
          end
          check("hold", bus.data_out, exp_hold);
        end
      end
    end
  end

  initial begin : stimulus
    bus.data_in_vld    = 1'b0;
    bus.data_in        = '0;
    bus.sync_clr       = 1'b0;
    bus.cfg_ratio_log2 = '0;
    bus.cfg_mode       = 1'b0;

    repeat (3) step(1'b0, '0, 1'b0, 1'b1);
    idle(1);
    check("reset_data", bus.data_out, '0);
    check("reset_vld", BW'(bus.data_out_vld), '0);

    // PICK, R=2, continuous ramp
    cur_r = 3'd2; cur_m = 1'b0;
    for (int i = 1; i <= 12; i++) step(1'b1, pack2(i, 100 + i), 1'b0, 1'b0);
    idle(2);

    // AVG, R=2, including a negative channel with a non-integer mean
    cur_m = 1'b1;
    step(1'b1, pack2(4, -1), 1'b0, 1'b0);
    step(1'b1, pack2(8, -2), 1'b0, 1'b0);
    step(1'b1, pack2(12, -2), 1'b0, 1'b0);
    step(1'b1, pack2(16, -2), 1'b0, 1'b0);
    idle(2);

    // R=0 pass-through with gaps, both modes
    cur_r = 3'd0;
    for (int m = 0; m < 2; m++) begin
      cur_m = m[0];
      for (int i = 0; i < 5; i++) begin
        idle(i % 4);
        step(1'b1, pack2(int'($urandom), int'($urandom)), 1'b0, 1'b0);
      end
    end
    idle(2);

    // Mid-group ratio change, then an out-of-range ratio
    cur_r = 3'd2; cur_m = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, pack2(10 * i + 3, -7 * i), 1'b0, 1'b0);
    cur_r = 3'd1;
    for (int i = 0; i < 6; i++) step(1'b1, pack2(5 * i - 9, 11 * i), 1'b0, 1'b0);
    cur_r = 3'd7;
    for (int i = 0; i < 32; i++) step(1'b1, pack2(i * i, -3 * i - 1), 1'b0, 1'b0);
    idle(2);

    // sync_clr with a coincident sample at phase 3
    cur_r = 3'd2; cur_m = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, pack2(50, 60), 1'b0, 1'b0);
    step(1'b1, pack2(99, 99), 1'b1, 1'b0);
    idle(2);
    for (int i = 1; i <= 4; i++) step(1'b1, pack2(i, -i), 1'b0, 1'b0);
    idle(2);

    // Reset mid-group, then R=1 PICK from the first sample
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, pack2(70 + i, 80 + i), 1'b0, 1'b0);
    cur_r = 3'd1; cur_m = 1'b0;
    step(1'b1, pack2(1, 1), 1'b0, 1'b1);
    idle(1);
    check("rst_mid_data", bus.data_out, '0);
    check("rst_mid_vld", BW'(bus.data_out_vld), '0);
    for (int i = 0; i < 4; i++) step(1'b1, pack2(200 + i, 300 + i), 1'b0, 1'b0);
    idle(2);

    // Randomized traffic with cfg churn, sync_clr and occasional reset
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) cur_r = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) cur_m = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 9) < 7),
           pack2(int'($urandom), int'($urandom)),
           1'($urandom_range(0, 59) == 0),
           1'($urandom_range(0, 399) == 0));
    end
    idle(4);
    check("scoreboard_drained", BW'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
